fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC loaded on reset (bits [1:0] SHALL be 0).
REQ-002 clk_i  input  1  sole clock; all state SHALL update on rising edge.
REQ-003 rst_ni  input  1  reset, synchronous and active-low.
REQ-004 imem_req_o  output  1  instruction memory read request, one-cycle pulse.
REQ-005 imem_addr_o  output  32  request address, valid when imem_req_o=1.
REQ-006 imem_rvalid_i  input  1  read data valid, arrives 1..N cycles after request.
REQ-007 imem_rdata_i  input  32  instruction word, valid with imem_rvalid_i.
REQ-008 instr_valid_o  output  1  instruction to decode is valid.
REQ-009 instr_o  output  32  fetched instruction.
REQ-010 opcode_o  output  7  instr_o[6:0], combinational, feeds the type decoder.
REQ-011 pc_o  output  32  address of instr_o.
REQ-012 decode_ready_i  input  1  decode accepts instr_o this cycle.
REQ-013 redirect_i  input  1  branch/jal/jalr taken; one-cycle pulse.
REQ-014 redirect_pc_i  input  32  redirect target.
REQ-015 fetch_cnt_o  output  32  accepted-instruction count (see Configuration).

Function
REQ-016 FSM states SHALL be IDLE, WAIT, VALID, DROP; at most one request outstanding.
REQ-017 IDLE: imem_req_o=1, imem_addr_o=pc, next state WAIT.
REQ-018 WAIT, imem_rvalid_i=1: instr_o<=imem_rdata_i, pc_o<=pc, pc<=pc+4, instr_valid_o<=1, next VALID.
REQ-019 VALID: instr_o, pc_o, instr_valid_o SHALL hold stable until instr_valid_o & decode_ready_i.
REQ-020 VALID handshake: imem_req_o=1, imem_addr_o=pc in same cycle, instr_valid_o<=0, next WAIT.
REQ-021 Redirect SHALL have priority over every other event in every state.
REQ-022 Redirect in IDLE or VALID: pc<=redirect_pc_i & ~32'h3, instr_valid_o<=0, no request that cycle, next IDLE.
REQ-023 Redirect in WAIT with imem_rvalid_i=1: response discarded, pc<=target, next IDLE.
REQ-024 Redirect in WAIT without imem_rvalid_i: pc<=target, next DROP.
REQ-025 DROP: next imem_rvalid_i discarded (no instr_valid_o), next IDLE; redirect in DROP updates pc, stays DROP.
REQ-026 Redirect coincident with VALID handshake: instruction counts as accepted, redirect wins, no request issued.
REQ-027 pc arithmetic modulo 2^32: 32'hFFFF_FFFC+4 SHALL wrap to 32'h0.
REQ-028 imem_rvalid_i in IDLE or VALID SHALL be ignored.
REQ-029 Minimum latency: request cycle -> rvalid next cycle -> instr_valid_o the cycle after.

Reset
REQ-030 rst_ni=0 at a rising edge: state IDLE, pc=RESET_PC, instr_valid_o=0, instr_o=0, pc_o=0, fetch_cnt_o=0.
REQ-031 During reset imem_req_o SHALL be 0; first request issued the cycle after rst_ni returns high.
REQ-032 Reset mid-transaction: any in-flight response arriving after reset SHALL be ignored (FSM in IDLE/WAIT of new request only).

Configuration
REQ-033 Macro FETCH_CNT_EN defined: fetch_cnt_o increments by 1 per instr_valid_o & decode_ready_i cycle, wraps at 2^32.
REQ-034 FETCH_CNT_EN undefined: no counter register, fetch_cnt_o tied to 32'h0.

Verification
REQ-035 Reset RESET_PC=0, memory returns 32'h0000_0033 after 1 cycle, ready=1 -> imem_addr_o 0,4,8; instr_valid_o with opcode_o=7'b0110011, pc_o=0.
REQ-036 Backpressure: decode_ready_i=0 for 5 cycles -> instr_o/pc_o stable, no new imem_req_o; ready=1 -> request at pc_o+4 same cycle.
REQ-037 Redirect in WAIT, rvalid 3 cycles later with 32'hDEAD_BEEF, target 32'h0000_0102 -> DEAD_BEEF never presented; next request addr 32'h0000_0100.
REQ-038 Redirect same cycle as rvalid in WAIT -> no instr_valid_o; next request at target.
REQ-039 RESET_PC=32'hFFFF_FFFC, one accepted fetch -> next imem_addr_o 32'h0000_0000.
REQ-040 FETCH_CNT_EN defined, 10 accepted fetches with 2 redirects interleaved -> fetch_cnt_o=10; undefined -> 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem read, holds the fetched word until decode takes it.
// Optional accepted-instruction counter is built when FETCH_CNT_EN is defined.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [6:0]  opcode_o,
    output logic [31:0] pc_o,
    input  logic        decode_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] fetch_cnt_o
);

    typedef enum logic [1:0] {StIdle, StWait, StValid, StDrop} state_e;

    state_e      state;
    logic [31:0] pc;
    logic        accept;

    assign accept      = instr_valid_o & decode_ready_i;
    assign opcode_o    = instr_o[6:0];
    assign imem_addr_o = pc;

    // A redirect suppresses the request; a stalled VALID never requests.
    assign imem_req_o = rst_ni & ~redirect_i &
                        ((state == StIdle) | ((state == StValid) & accept));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state         <= StIdle;
            pc            <= RESET_PC & ~32'h3;
            instr_valid_o <= 1'b0;
            instr_o       <= 32'h0;
            pc_o          <= 32'h0;
        end else if (redirect_i) begin
            pc            <= redirect_pc_i & ~32'h3;
            instr_valid_o <= 1'b0;
            // A response still in flight must be swallowed before refetching.
            if (((state == StWait) || (state == StDrop)) && !imem_rvalid_i) begin
                state <= StDrop;
            end else begin
                state <= StIdle;
            end
        end else begin
            unique case (state)
                StIdle: state <= StWait;
                StWait: begin
                    if (imem_rvalid_i) begin
                        instr_o       <= imem_rdata_i;
                        pc_o          <= pc;
                        pc            <= pc + 32'd4;
                        instr_valid_o <= 1'b1;
                        state         <= StValid;
                    end
                end
                StValid: begin
                    if (accept) begin
                        instr_valid_o <= 1'b0;
                        state         <= StWait;
                    end
                end
                StDrop: begin
                    if (imem_rvalid_i) begin
                        state <= StIdle;
                    end
                end
            endcase
        end
    end

`ifdef FETCH_CNT_EN
    logic [31:0] fetch_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fetch_cnt <= 32'h0;
        end else if (accept) begin
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

    assign fetch_cnt_o = fetch_cnt;
`else
    assign fetch_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: random memory latency, backpressure and redirects checked against
// an address-stream model; FETCH_CNT_EN selects the expected counter behaviour.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [6:0]  opcode_o;
    logic [31:0] pc_o;
    logic        decode_ready_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] fetch_cnt_o;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_rvalid_i  (imem_rvalid_i),
        .imem_rdata_i   (imem_rdata_i),
        .instr_valid_o  (instr_valid_o),
        .instr_o        (instr_o),
        .opcode_o       (opcode_o),
        .pc_o           (pc_o),
        .decode_ready_i (decode_ready_i),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .fetch_cnt_o    (fetch_cnt_o)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] tgt_q[$];     // redirect targets, pushed by the driver, consumed by the monitor
    logic [31:0] cur_pc;       // address the decoder must see next
    logic [31:0] acc_cnt;
    int          lat_mode = 1; // 0: random latency 1..4
    bit          corrupt = 1'b0;
    bit          stray_en = 1'b0;

    bit          pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr;
    bit          pcor;

    bit          hold = 1'b0;
    bit          rst_prev = 1'b0;
    logic [31:0] h_pc;
    logic [31:0] h_instr;
    logic [31:0] e_word;

    function automatic logic [31:0] mem(input logic [31:0] a);
        logic [31:0] h;
        h = a * 32'h9E37_79B9 + 32'h0123_4567;
        return h ^ (h >> 13);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Memory: one response per request after 1..4 cycles, optional stray rvalid when idle.
    initial begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'h0;
            if (pend) begin
                if (cnt <= 1) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = pcor ? 32'hDEAD_BEEF : mem(paddr);
                    pend          = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (stray_en && $urandom_range(0, 7) == 0) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = $urandom;
            end
            @(negedge clk);
            if (imem_req_o) begin
                check1("one_outstanding", pend, 1'b0);
                pend  = 1'b1;
                paddr = imem_addr_o;
                pcor  = corrupt;
                cnt   = (lat_mode != 0) ? lat_mode : int'($urandom_range(1, 4));
            end
        end
    end

    // Monitor: compares every presented instruction and request against the stream model.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                check1("req_in_reset", imem_req_o, 1'b0);
                if (rst_prev) begin
                    check1("rst_instr_valid", instr_valid_o, 1'b0);
                    check("rst_instr", instr_o, 32'h0);
                    check("rst_pc_o", pc_o, 32'h0);
                    check("rst_fetch_cnt", fetch_cnt_o, 32'h0);
                end
                rst_prev = 1'b1;
                cur_pc   = RST_PC;
                acc_cnt  = 32'h0;
                hold     = 1'b0;
                tgt_q.delete();
            end else begin
                rst_prev = 1'b0;
`ifdef FETCH_CNT_EN
                check("fetch_cnt", fetch_cnt_o, acc_cnt);
`else
                check("fetch_cnt", fetch_cnt_o, 32'h0);
`endif
                if (hold) begin
                    check1("hold_valid", instr_valid_o, 1'b1);
                    check("hold_pc", pc_o, h_pc);
                    check("hold_instr", instr_o, h_instr);
                end
                if (instr_valid_o) begin
                    e_word = mem(cur_pc);
                    check("pc_o", pc_o, cur_pc);
                    check("instr_o", instr_o, e_word);
                    check("opcode_o", {25'h0, opcode_o}, {25'h0, e_word[6:0]});
                    if (decode_ready_i) begin
                        cur_pc  = cur_pc + 32'd4;
                        acc_cnt = acc_cnt + 32'd1;
                    end else begin
                        check1("no_req_stall", imem_req_o, 1'b0);
                    end
                end
                hold    = instr_valid_o && !decode_ready_i && !redirect_i;
                h_pc    = pc_o;
                h_instr = instr_o;
                if (redirect_i) begin
                    check1("no_req_on_redirect", imem_req_o, 1'b0);
                    if (tgt_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL redirect_queue: got empty expected a target");
                    end else begin
                        cur_pc = tgt_q.pop_front();
                    end
                end else if (imem_req_o) begin
                    check("req_addr", imem_addr_o, cur_pc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic redir(input logic [31:0] t);
        redirect_i    = 1'b1;
        redirect_pc_i = t;
        tgt_q.push_back(t & ~32'h3);
    endtask

    task automatic wait_req();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imem_req_o) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_req: got no request expected one within 20 cycles");
        end
    endtask

    task automatic random_run(input int n, input int redir_mod);
        for (int i = 0; i < n; i++) begin
            cyc();
            decode_ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, redir_mod - 1) == 0) begin
                redir($urandom);
            end else begin
                redirect_i = 1'b0;
            end
        end
        cyc();
        redirect_i     = 1'b0;
        decode_ready_i = 1'b1;
    endtask

    initial begin
        rst_ni         = 1'b0;
        decode_ready_i = 1'b1;
        redirect_i     = 1'b0;
        redirect_pc_i  = 32'h0;
        repeat (3) cyc();
        rst_ni = 1'b1;

        // Minimum latency from first request (at RESET_PC) to presented instruction.
        wait_req();
        @(negedge clk);
        check1("lat_cycle1", instr_valid_o, 1'b0);
        @(negedge clk);
        check1("lat_cycle2", instr_valid_o, 1'b1);
        repeat (8) cyc();

        // Backpressure.
        decode_ready_i = 1'b0;
        repeat (6) cyc();
        decode_ready_i = 1'b1;
        repeat (4) cyc();

        // Redirect in WAIT; late response carries DEAD_BEEF and must be dropped.
        lat_mode = 3;
        corrupt  = 1'b1;
        wait_req();
        cyc();
        corrupt = 1'b0;
        redir(32'h0000_0102);
        cyc();
        redirect_i = 1'b0;
        lat_mode   = 1;
        repeat (8) cyc();

        // Redirect coincident with rvalid.
        wait_req();
        cyc();
        redir($urandom);
        cyc();
        redirect_i = 1'b0;
        repeat (6) cyc();

        lat_mode = 0;
        stray_en = 1'b1;
        random_run(400, 12);
        stray_en = 1'b0;

        // Reset in the middle of traffic.
        rst_ni = 1'b0;
        repeat (6) cyc();
        rst_ni = 1'b1;
        random_run(80, 20);
        repeat (10) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
